// File: rtl/multi_initiator_pkg.sv
// rtl/multi_initiator_pkg.sv - shared types and constants for the start/done initiator
//
// Holds the initiator FSM state encoding, default parameter values and the
// helper that sizes the wait counter so it can hold 0..TIMEOUT.
package multi_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_TIMEOUT = 15;
  localparam int DEF_CNT_W   = 8;

  // Bits needed for a counter that can reach TIMEOUT.
  function automatic int wait_cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/multi_initiator_sat.sv
// rtl/multi_initiator_sat.sv - saturating event counter for initiator statistics
//
// Ports:
//   clock  clock
//   reset  synchronous, active-high; clears value
//   inc    count one event this cycle
//   value  current count, sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/multi_initiator.sv
// rtl/multi_initiator.sv - stream-to-start/done initiator with timeout and statistics
//
// Accepts one request at a time, fires a single-cycle start pulse at the
// attached unit with the operand held on unit_inp, waits for done (or gives
// up after TIMEOUT wait cycles) and returns the result on the response stream.
//
// Ports:
//   clock, reset            clock; synchronous active-high reset
//   req_valid/ready/data    request stream (ready only in IDLE)
//   unit_start, unit_inp    start pulse and held operand to the unit
//   unit_done, unit_out     completion strobe and result from the unit
//   rsp_valid/ready/data    response stream, data 0 on timeout
//   rsp_timeout             response is a timeout (qualified by rsp_valid)
//   busy                    transaction in progress
//   done_count              completed transactions, saturating
//   timeout_count           timed-out transactions, saturating
module multi_initiator
  import multi_initiator_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  output logic             unit_start,
  output logic [WIDTH-1:0] unit_inp,
  input  logic             unit_done,
  input  logic [WIDTH-1:0] unit_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] done_count,
  output logic [CNT_W-1:0] timeout_count
);

  localparam int             WCW       = wait_cnt_width(TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  state_t         state, state_next;
  logic [WCW-1:0] wait_cnt;
  logic           done_hit;
  logic           timeout_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // done_hit/timeout_hit are only raised in WAIT, so a stray done in any
  // other state has no effect. Done takes priority over the timeout.
  always_comb begin
    state_next  = state;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    req_ready   = 1'b0;
    unit_start  = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_next = START;
      end
      START: begin
        unit_start = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (unit_done) begin
          done_hit   = 1'b1;
          state_next = RESP;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      unit_inp    <= '0;
      wait_cnt    <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if ((state == IDLE) && req_valid) unit_inp <= req_data;

      // Counter leaves WAIT at TIMEOUT-1, so it never wraps.
      if (state == START) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + WCW'(1);
      end

      if (done_hit) begin
        rsp_data    <= unit_out;
        rsp_timeout <= 1'b0;
      end else if (timeout_hit) begin
        rsp_data    <= '0;
        rsp_timeout <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_done_count (
    .clock (clock),
    .reset (reset),
    .inc   (done_hit),
    .value (done_count)
  );

  sat_counter #(.W(CNT_W)) u_timeout_count (
    .clock (clock),
    .reset (reset),
    .inc   (timeout_hit),
    .value (timeout_count)
  );

endmodule
